instr_fetch: RTL

Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter and issues word reads to instruction memory over a single-outstanding req/ack handshake. Buffers returned words with their PCs in a small FIFO and presents them to the decoder on a valid/ready interface. Handles control-flow redirects from the flow-control unit, including flushing the FIFO and discarding an in-flight response.

---
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles every signal of the instruction fetch stage except clk/reset.
//   imem_req/imem_addr      : fetch -> instruction memory read request
//   imem_ack/imem_rdata     : instruction memory -> fetch response
//   instr_valid/instr/instr_pc, instr_ready : fetch <-> decoder stream
//   redirect/redirect_pc    : flow-control unit -> fetch restart
//   halt                    : decoder exception, stops fetching
//   fetch_fault             : sticky misaligned-redirect flag
// master = the fetch stage, slave = its environment (memory, decoder, flow control).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch stage: owns the PC, issues single-outstanding word reads
// to instruction memory, buffers returned words with their PCs in a circular
// FIFO and presents the head to the decoder on a valid/ready stream.
// Ports:
//   clk   : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : instr_fetch_if.master (memory request/response, decoder stream,
//           redirect, halt, fetch_fault)
// Parameters:
//   RESET_PC   : word-aligned PC of the first fetch after reset
//   FIFO_DEPTH : instruction buffer entries, power of two, >= 2
// Optional feature macro: INSTR_FETCH_ALIGN_CHECK_EN
//   defined     : misaligned redirect sets sticky fetch_fault and stops fetching
//   not defined : redirect_pc[1:0] is forced to zero, fetch_fault tied low
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [31:0]   req_addr, req_addr_next;
    logic [CW-1:0] count, count_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic          halt_q, fault_q;

    logic          outstanding, still_out, halt_now, redirect_take;
    logic          fault_set, stopped, flush, push, pop, issue;
    logic [31:0]   target_pc;

    // Next-state, FIFO control and PC update. Halt outranks redirect, and
    // either one outranks a same-cycle push or pop. Whenever a request
    // completes (or none is outstanding) and nothing blocks fetching, the
    // next request is issued straight away at pc_next.
    always_comb begin
        state_next    = state;
        req_addr_next = req_addr;
        issue         = 1'b0;

        outstanding   = (state == WAIT) || (state == DROP);
        still_out     = outstanding && !bus.imem_ack;
        halt_now      = (state != HALTED) && (bus.halt || halt_q);
        redirect_take = (state != HALTED) && !halt_now && bus.redirect;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        fault_set = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
        target_pc = bus.redirect_pc;
`else
        fault_set = 1'b0;
        target_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

        stopped = fault_q || fault_set;
        flush   = halt_now || redirect_take;
        push    = (state == WAIT) && bus.imem_ack && !flush;
        pop     = (count != '0) && bus.instr_ready && !flush;

        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end

        if (redirect_take) begin
            pc_next = target_pc;
        end else if (push) begin
            pc_next = pc + 32'd4;
        end else begin
            pc_next = pc;
        end

        if (state == HALTED) begin
            state_next = HALTED;
        end else if (halt_now) begin
            state_next = still_out ? DROP : HALTED;
        end else if (stopped) begin
            state_next = still_out ? DROP : IDLE;
        end else if (redirect_take) begin
            if (still_out) begin
                state_next = DROP;
            end else begin
                issue = 1'b1;
            end
        end else begin
            case (state)
                // A pop in this cycle is deliberately not credited here.
                IDLE: issue = (count < DEPTH_C);
                WAIT: begin
                    if (bus.imem_ack) begin
                        state_next = IDLE;
                        issue      = (count_next < DEPTH_C);
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_next = IDLE;
                        issue      = (count_next < DEPTH_C);
                    end
                end
                default: state_next = state;
            endcase
        end

        if (issue) begin
            state_next    = WAIT;
            req_addr_next = pc_next;
        end
    end

    // Control state: FSM, PC, request address, occupancy and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            halt_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
            if (halt_now) begin
                halt_q <= 1'b1;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Instruction buffer storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= pc;
        end
    end

    assign bus.imem_req    = outstanding;
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = buf_instr[rd_ptr];
    assign bus.instr_pc    = buf_pc[rd_ptr];
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule
